// File: rtl/pe_input_fifo.sv
// Operand FIFO feeding the PE controller; a word retires only on pe_ack.
// Latency 1 cycle (0 for first word when PE_INPUT_FIFO_BYPASS_EN is defined).
// Backpressure: o_ready low while full, independent of pe_ack.
module pe_input_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_valid,
  input  logic                       pe_ack,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       o_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  err_q;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  bypass_hit;
  logic                  wr_en;
  logic                  rd_en;

  assign empty = (count_q == '0);

  always_comb begin
    o_ready = (count_q != FULL_CNT);
    o_valid = !empty;
    o_data  = mem[rd_ptr];
`ifdef PE_INPUT_FIFO_BYPASS_EN
    // Empty FIFO forwards the upstream word straight through to the PE.
    if (empty) begin
      o_valid = i_valid;
      o_data  = i_data;
    end
`endif
  end

  assign push = i_valid && o_ready;
  assign pop  = pe_ack && o_valid;

`ifdef PE_INPUT_FIFO_BYPASS_EN
  // A word consumed in the same cycle it arrived at an empty FIFO never lands in storage.
  assign bypass_hit = pop && empty;
`else
  assign bypass_hit = 1'b0;
`endif

  assign wr_en = push && !bypass_hit;
  assign rd_en = pop && !bypass_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (pe_ack && !o_valid) err_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= i_data;
  end

  assign count = count_q;
  assign o_err = err_q;

endmodule

// File: tb/tb_pe_input_fifo.sv
// Directed bench for pe_input_fifo (DEPTH=4, DATA_WIDTH=16).
module tb_pe_input_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_data;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] o_data;
  logic        o_valid;
  logic        pe_ack;
  logic [2:0]  count;
  logic        o_err;

  int n_cmp = 0;
  int n_err = 0;

  pe_input_fifo #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .pe_ack  (pe_ack),
    .count   (count),
    .o_err   (o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] fill [4];
    int wr_idx;
    int rd_idx;
    int cyc_n;
    logic acc;
    logic popd;

    fill[0] = 16'h0011; fill[1] = 16'h0022; fill[2] = 16'h0033; fill[3] = 16'h0044;
    rst = 1'b1; i_valid = 1'b0; i_data = '0; pe_ack = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    check("rst_count",   32'(count),   0);
    check("rst_o_valid", 32'(o_valid), 0);
    check("rst_o_ready", 32'(o_ready), 1);
    check("rst_o_err",   32'(o_err),   0);

    // Fill to full with no acks
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_data = fill[i];
      cyc();
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("full_o_ready", 32'(o_ready), 0);
    i_data = 16'h0055;
    cyc();
    check("refused_count", 32'(count),  4);
    check("refused_head",  32'(o_data), 32'h0011);
    i_valid = 1'b0;

    // Drain two, then simultaneous push/pop at count 2
    pe_ack = 1'b1;
    cyc();
    check("pop1_count", 32'(count),  3);
    check("pop1_head",  32'(o_data), 32'h0022);
    cyc();
    check("pop2_count", 32'(count),  2);
    check("pop2_head",  32'(o_data), 32'h0033);
    i_valid = 1'b1; i_data = 16'h00AA;
    cyc();
    check("pushpop_count", 32'(count),  2);
    check("pushpop_head",  32'(o_data), 32'h0044);
    i_valid = 1'b0;
    cyc();
    check("aa_count", 32'(count),  1);
    check("aa_head",  32'(o_data), 32'h00AA);
    cyc();
    check("drain_count", 32'(count), 0);
    pe_ack = 1'b0;

    // Stream 10 words through the wrapping pointers, acking every other cycle
    wr_idx = 0; rd_idx = 0; cyc_n = 0;
    while (rd_idx < 10 && cyc_n < 100) begin
      i_valid = (wr_idx < 10);
      i_data  = 16'(wr_idx + 1);
      pe_ack  = cyc_n[0];
      #1;
      popd = pe_ack && o_valid;
      if (popd) check("stream_word", 32'(o_data), 32'(rd_idx + 1));
      acc = i_valid && o_ready;
      @(posedge clk);
      #1;
      if (popd) rd_idx++;
      if (acc) wr_idx++;
      cyc_n++;
    end
    i_valid = 1'b0; pe_ack = 1'b0;
    check("stream_popped",  32'(rd_idx), 10);
    check("stream_written", 32'(wr_idx), 10);
    check("stream_count",   32'(count),  0);
    check("stream_no_err",  32'(o_err),  0);

    // Ack on an empty FIFO is a protocol error and sticks
    pe_ack = 1'b1;
    cyc();
    pe_ack = 1'b0;
    check("perr_count", 32'(count), 0);
    check("perr_flag",  32'(o_err), 1);
    cyc(); cyc();
    check("perr_sticky", 32'(o_err), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("perr_cleared", 32'(o_err), 0);

    // Same-cycle word and ack on an empty FIFO
    i_valid = 1'b1; i_data = 16'h1234; pe_ack = 1'b1;
    #1;
`ifdef PE_INPUT_FIFO_BYPASS_EN
    check("byp_o_valid", 32'(o_valid), 1);
    check("byp_o_data",  32'(o_data),  32'h1234);
    cyc();
    i_valid = 1'b0; pe_ack = 1'b0;
    check("byp_count", 32'(count), 0);
    check("byp_err",   32'(o_err), 0);
`else
    check("nobyp_o_valid", 32'(o_valid), 0);
    cyc();
    i_valid = 1'b0; pe_ack = 1'b0;
    check("nobyp_count", 32'(count),  1);
    check("nobyp_err",   32'(o_err),  1);
    check("nobyp_head",  32'(o_data), 32'h1234);
`endif

    // Reset mid-stream discards stored words
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_count",   32'(count),   0);
    check("rst2_o_valid", 32'(o_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
